// File: rtl/sample_capture_seq_pkg.sv
// sew_capture_pkg: shared state type and constants for the
// sample capture sequencer and its trigger detector.
package sew_capture_pkg;

   localparam int DATA_W = 11;
   localparam int IDX_W  = 6;
   localparam int DEPTH  = 2 ** IDX_W;

   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } cap_state_t;

endpackage

// File: rtl/capture_trig_detect.sv
// capture_trig_detect: level-crossing detector; remembers the last
// valid armed sample and flags a crossing against trig_level.
module capture_trig_detect #(
   parameter int DATA_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              enable,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   output logic              hit
);
   import sew_capture_pkg::*;

   logic [DATA_W-1:0] prev;
   logic              prev_valid;
   logic              rise;
   logic              fall;

   // Hold the previous valid sample seen while armed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (clr) begin
         prev_valid <= 1'b0;
      end else if (enable && sample_valid) begin
         prev       <= sample_in;
         prev_valid <= 1'b1;
      end
   end

   // Crossing between the held sample and the current one.
   always_comb begin
      rise = (prev < trig_level) && (sample_in >= trig_level);
      fall = (prev > trig_level) && (sample_in <= trig_level);
      hit  = 1'b0;
      if (enable && sample_valid && prev_valid) begin
         hit = (trig_slope == SLOPE_FALL) ? fall : rise;
      end
   end

endmodule

// File: rtl/sample_capture_seq.sv
// sample_capture_seq: arms on request, waits for a level crossing, then
// writes 64 decimated samples. Option macro: AUTO_TRIG_EN.
module sample_capture_seq #(
   parameter int DATA_W  = 11,
   parameter int IDX_W   = 6,
   parameter int DECIM_W = 8
`ifdef AUTO_TRIG_EN
   ,
   parameter int AUTO_TIMEOUT = 1000000
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATA_W-1:0]  sample_in,
   input  logic               sample_valid,
   input  logic               arm,
   input  logic [DATA_W-1:0]  trig_level,
   input  logic               trig_slope,
   input  logic [DECIM_W-1:0] decim,
   output logic [DATA_W-1:0]  data,
   output logic [IDX_W-1:0]   data_change,
   output logic               wr_stb,
   output logic               busy,
`ifdef AUTO_TRIG_EN
   output logic               auto_trig,
`endif
   output logic               done
);
   import sew_capture_pkg::*;

   localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

   cap_state_t         state;
   cap_state_t         state_n;
   logic [IDX_W-1:0]   idx;
   logic [DECIM_W-1:0] decim_q;
   logic [DECIM_W-1:0] dcnt;
   logic               arm_go;
   logic               wr_en;
   logic               armed;
   logic               hit;
   logic               trig;

   assign armed = (state == ARMED);
   assign busy  = (state == ARMED) || (state == CAPTURE);
   assign done  = (state == DONE);

   capture_trig_detect #(
      .DATA_W(DATA_W)
   ) u_trig (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (arm_go),
      .enable       (armed),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .trig_level   (trig_level),
      .trig_slope   (trig_slope),
      .hit          (hit)
   );

`ifdef AUTO_TRIG_EN
   localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
   localparam logic [TW-1:0] TLAST = TW'(AUTO_TIMEOUT - 1);

   logic [TW-1:0] tcnt;
   logic          forced;

   // Once the dwell timer expires the next valid sample fires.
   assign forced = armed && sample_valid && (tcnt == TLAST);
   assign trig   = hit || forced;

   // ARMED dwell timer; saturates at the forced-trigger point.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (arm_go) begin
         tcnt <= '0;
      end else if (armed && (tcnt != TLAST)) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Marks a capture started by timeout rather than a crossing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         auto_trig <= 1'b0;
      end else if (arm_go) begin
         auto_trig <= 1'b0;
      end else if (forced && !hit) begin
         auto_trig <= 1'b1;
      end
   end
`else
   assign trig = hit;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state plus the arm and write decisions for this cycle.
   always_comb begin
      state_n = state;
      arm_go  = 1'b0;
      wr_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm) begin
               arm_go  = 1'b1;
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (trig) begin
               wr_en   = 1'b1;
               state_n = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample_valid && (dcnt == decim_q)) begin
               wr_en = 1'b1;
               if (idx == IDX_LAST) begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            if (arm) begin
               arm_go  = 1'b1;
               state_n = ARMED;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Decimation counter, slot index and the bank write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         decim_q     <= '0;
         dcnt        <= '0;
         idx         <= '0;
         data        <= '0;
         data_change <= '0;
         wr_stb      <= 1'b0;
      end else begin
         wr_stb <= wr_en;
         if (arm_go) begin
            decim_q <= decim;
            dcnt    <= '0;
            idx     <= '0;
         end
         if ((state == CAPTURE) && sample_valid) begin
            if (dcnt == decim_q) begin
               dcnt <= '0;
            end else begin
               dcnt <= dcnt + 1'b1;
            end
         end
         if (wr_en) begin
            data        <= sample_in;
            data_change <= idx;
            idx         <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sample_capture_seq.sv
// tb_sample_capture_seq: scoreboard bench for sample_capture_seq.
// Expected writes are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_sample_capture_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] sample_in;
   logic        sample_valid;
   logic        arm;
   logic [10:0] trig_level;
   logic        trig_slope;
   logic [7:0]  decim;
   logic [10:0] data;
   logic [5:0]  data_change;
   logic        wr_stb;
   logic        busy;
   logic        done;
`ifdef AUTO_TRIG_EN
   logic        auto_trig;
`endif

   typedef struct packed {
      logic [10:0] d;
      logic [5:0]  i;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks   = 0;
   int   errors   = 0;
   int   n_strobe = 0;

   always #5 clk = ~clk;

   sample_capture_seq #(
      .DATA_W(11),
      .IDX_W(6),
      .DECIM_W(8)
`ifdef AUTO_TRIG_EN
      ,
      .AUTO_TIMEOUT(16)
`endif
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .arm          (arm),
      .trig_level   (trig_level),
      .trig_slope   (trig_slope),
      .decim        (decim),
      .data         (data),
      .data_change  (data_change),
      .wr_stb       (wr_stb),
      .busy         (busy),
`ifdef AUTO_TRIG_EN
      .auto_trig    (auto_trig),
`endif
      .done         (done)
   );

   // Scoreboard: every strobe must match the oldest queued write.
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         n_strobe++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_strobe data=%0d idx=%0d want no strobe",
                     data, data_change);
         end else begin
            e = exp_q.pop_front();
            if (data !== e.d || data_change !== e.i) begin
               errors++;
               $display("FAIL strobe got data=%0d idx=%0d want data=%0d idx=%0d",
                        data, data_change, e.d, e.i);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int s, input bit v, input bit a);
      sample_in    = 11'(s);
      sample_valid = v;
      arm          = a;
      @(negedge clk);
   endtask

   task automatic push(input int d, input int i);
      exp_t x;
      x.d = 11'(d);
      x.i = 6'(i);
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(0, 1'b0, 1'b1);
      cyc(0, 1'b0, 1'b1);
      checks++; if (data !== 11'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", data); end
      checks++; if (data_change !== 6'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", data_change); end
      checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b want=0", wr_stb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      rst_n = 1'b1;
      cyc(0, 1'b0, 1'b0);
   endtask

   task automatic test_rising();
      n_strobe   = 0;
      trig_level = 11'd512;
      trig_slope = 1'b0;
      decim      = 8'd0;
      cyc(0, 1'b0, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy got=%b want=1", busy); end
      cyc(500, 1'b1, 1'b0);
      cyc(510, 1'b1, 1'b0);
      push(520, 0);
      cyc(520, 1'b1, 1'b0);
      for (int k = 1; k < 64; k++) begin
         push(520 + 10 * k, k);
         cyc(520 + 10 * k, 1'b1, 1'b0);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rise_done got=%b want=1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rise_busy_end got=%b want=0", busy); end
      checks++; if (data_change !== 6'd63) begin errors++; $display("FAIL rise_last_idx got=%0d want=63", data_change); end
`ifdef AUTO_TRIG_EN
      checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL rise_auto got=%b want=0", auto_trig); end
`endif
      for (int k = 0; k < 4; k++) cyc(1200, 1'b1, 1'b0);
      checks++; if (n_strobe != 64) begin errors++; $display("FAIL rise_count got=%0d want=64", n_strobe); end
      checks++; if (data_change !== 6'd63) begin errors++; $display("FAIL rise_hold_idx got=%0d want=63", data_change); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rise_queue got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_falling_decim();
      int s;
      n_strobe   = 0;
      trig_level = 11'd100;
      trig_slope = 1'b1;
      decim      = 8'd2;
      cyc(0, 1'b0, 1'b1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rearm_done got=%b want=0", done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got=%b want=1", busy); end
      decim = 8'd0;
      cyc(200, 1'b1, 1'b0);
      cyc(150, 1'b1, 1'b0);
      push(90, 0);
      cyc(90, 1'b1, 1'b0);
      for (int j = 1; j <= 189; j++) begin
         s = 79 + j;
         if (j % 3 == 0) push(s, j / 3);
         cyc(s, 1'b1, 1'b0);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL fall_done got=%b want=1", done); end
      for (int k = 0; k < 6; k++) cyc(50, 1'b1, 1'b0);
      checks++; if (n_strobe != 64) begin errors++; $display("FAIL fall_count got=%0d want=64", n_strobe); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fall_queue got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_gating();
      n_strobe   = 0;
      trig_level = 11'd512;
      trig_slope = 1'b0;
      decim      = 8'd0;
      cyc(0, 1'b0, 1'b1);
      cyc(600, 1'b1, 1'b0);
      cyc(700, 1'b1, 1'b0);
      checks++; if (n_strobe != 0) begin errors++; $display("FAIL gate_no_first_trig got=%0d want=0", n_strobe); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy got=%b want=1", busy); end
      cyc(500, 1'b1, 1'b0);
      push(600, 0);
      cyc(600, 1'b1, 1'b0);
      for (int k = 1; k < 64; k++) begin
         cyc(2047, 1'b0, k == 20);
         push(1000 + k, k);
         cyc(1000 + k, 1'b1, k == 40);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL gate_done got=%b want=1", done); end
      for (int k = 0; k < 4; k++) cyc(2047, 1'b1, 1'b0);
      checks++; if (n_strobe != 64) begin errors++; $display("FAIL gate_count got=%0d want=64", n_strobe); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gate_queue got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      n_strobe   = 0;
      trig_level = 11'd512;
      trig_slope = 1'b0;
      decim      = 8'd0;
      cyc(0, 1'b0, 1'b1);
      cyc(500, 1'b1, 1'b0);
      push(520, 0);
      cyc(520, 1'b1, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         push(520 + k, k);
         cyc(520 + k, 1'b1, 1'b0);
      end
      rst_n = 1'b0;
      cyc(900, 1'b1, 1'b1);
      checks++; if (data !== 11'd0) begin errors++; $display("FAIL mid_data got=%0d want=0", data); end
      checks++; if (data_change !== 6'd0) begin errors++; $display("FAIL mid_idx got=%0d want=0", data_change); end
      checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL mid_stb got=%b want=0", wr_stb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b want=0", done); end
      checks++; if (n_strobe != 31) begin errors++; $display("FAIL mid_count got=%0d want=31", n_strobe); end
      rst_n = 1'b1;
      cyc(900, 1'b1, 1'b0);
      cyc(100, 1'b1, 1'b0);
      cyc(900, 1'b1, 1'b0);
      checks++; if (n_strobe != 31) begin errors++; $display("FAIL idle_count got=%0d want=31", n_strobe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
      cyc(0, 1'b0, 1'b1);
      cyc(500, 1'b1, 1'b0);
      push(600, 0);
      cyc(600, 1'b1, 1'b0);
      for (int k = 1; k < 64; k++) begin
         push(600 + k, k);
         cyc(600 + k, 1'b1, 1'b0);
      end
      cyc(0, 1'b0, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b want=1", done); end
      checks++; if (n_strobe != 95) begin errors++; $display("FAIL restart_count got=%0d want=95", n_strobe); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_queue got=%0d want=0", exp_q.size()); end
   endtask

`ifdef AUTO_TRIG_EN
   task automatic test_auto();
      n_strobe   = 0;
      trig_level = 11'd512;
      trig_slope = 1'b0;
      decim      = 8'd0;
      cyc(0, 1'b0, 1'b1);
      for (int c = 1; c < 16; c++) cyc(c, 1'b1, 1'b0);
      checks++; if (n_strobe != 0) begin errors++; $display("FAIL auto_early got=%0d want=0", n_strobe); end
      checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL auto_early_flag got=%b want=0", auto_trig); end
      push(16, 0);
      cyc(16, 1'b1, 1'b0);
      checks++; if (auto_trig !== 1'b1) begin errors++; $display("FAIL auto_flag got=%b want=1", auto_trig); end
      for (int k = 1; k < 64; k++) begin
         push(100 + k, k);
         cyc(100 + k, 1'b1, 1'b0);
      end
      cyc(0, 1'b0, 1'b0);
      checks++; if (n_strobe != 64) begin errors++; $display("FAIL auto_count got=%0d want=64", n_strobe); end
      cyc(0, 1'b0, 1'b1);
      checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL auto_clear got=%b want=0", auto_trig); end
   endtask
`endif

   initial begin
      rst_n        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      arm          = 1'b0;
      trig_level   = '0;
      trig_slope   = 1'b0;
      decim        = '0;
      @(negedge clk);
      test_reset();
      test_rising();
      test_falling_decim();
      test_gating();
      test_reset_mid();
`ifdef AUTO_TRIG_EN
      test_auto();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
